// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the core (C) and an external
// master (X); serialises accesses, holds enable for the read latency and returns data.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_gnt,
    output logic              x_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                owner_x_q, owner_x_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                c_gnt_q, c_gnt_d;
    logic                x_gnt_q, x_gnt_d;
    logic                c_rvalid_q, c_rvalid_d;
    logic                x_rvalid_q, x_rvalid_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                x_starved;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_x_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            rdata_q    <= '0;
            c_gnt_q    <= 1'b0;
            x_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            x_rvalid_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_x_q  <= owner_x_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            rdata_q    <= rdata_d;
            c_gnt_q    <= c_gnt_d;
            x_gnt_q    <= x_gnt_d;
            c_rvalid_q <= c_rvalid_d;
            x_rvalid_q <= x_rvalid_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
        end
    end

    assign x_starved = x_req && (starve_q == STV_W'(STARVE_LIM));

    // Next state, arbitration and next output values
    always_comb begin
        state_d   = state_q;
        owner_x_d = owner_x_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (c_req || x_req) begin
                    state_d = S_ACCESS;
                    if (c_req && !x_starved) begin
                        owner_x_d = 1'b0;
                        we_d      = c_we;
                        addr_d    = c_addr;
                        wdata_d   = c_wdata;
                        if (!x_req) begin
                            starve_d = '0;
                        end else if (starve_q != STV_W'(STARVE_LIM)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end else begin
                        owner_x_d = 1'b1;
                        we_d      = x_we;
                        addr_d    = x_addr;
                        wdata_d   = x_wdata;
                        starve_d  = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_W'(1);
                end else begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        c_gnt_d    = (state_q == S_IDLE) && (state_d == S_ACCESS) && !owner_x_d;
        x_gnt_d    = (state_q == S_IDLE) && (state_d == S_ACCESS) && owner_x_d;
        c_rvalid_d = (state_d == S_RESP) && !owner_x_q;
        x_rvalid_d = (state_d == S_RESP) && owner_x_q;
        mem_en_d   = (state_d == S_ACCESS) || (state_d == S_WAIT);
        mem_we_d   = (state_d == S_ACCESS) && we_d;
        busy_d     = (state_d != S_IDLE);
    end

    assign c_gnt     = c_gnt_q;
    assign x_gnt     = x_gnt_q;
    assign c_rvalid  = c_rvalid_q;
    assign x_rvalid  = x_rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, starvation/reset sequences
// and a randomized two-master run checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, x_req, x_we;
    logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
    logic        c_gnt, c_rvalid, x_gnt, x_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_rvalid(x_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Contents of never-written words, shared by memory macro and model
    function automatic logic [31:0] default_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
    endfunction

    // Memory macro: one-cycle registered read, so data is ready on the 2nd enable cycle
    bit [31:0] mem_arr [0:255];
    bit        mem_vld [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            mem_vld[mem_addr[9:2]] <= 1'b1;
        end
        mem_rdata <= mem_vld[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : default_word(mem_addr);
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] last_rd;

    // One transaction from an idle arbiter; caller is #1 after a rising edge
    task automatic run_txn(input bit px, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
        if (px) begin
            x_req = 1'b1; x_we = we; x_addr = a; x_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
        end
        @(posedge clk); #1;
        chk1("txn_gnt_owner", px ? x_gnt : c_gnt, 1'b1);
        chk1("txn_gnt_other", px ? c_gnt : x_gnt, 1'b0);
        chk1("txn_acc_mem_en", mem_en, 1'b1);
        chk1("txn_acc_mem_we", mem_we, we);
        chk32("txn_acc_mem_addr", mem_addr, a);
        if (we) chk32("txn_acc_mem_wdata", mem_wdata, wd);
        chk1("txn_acc_busy", busy, 1'b1);
        // Requester drops the request and scribbles the address once granted
        c_req = 1'b0; x_req = 1'b0;
        c_addr = ~a; x_addr = ~a; c_wdata = ~wd; x_wdata = ~wd;
        if (we) begin
            model_mem[a] = wd;
        end else begin
            for (int k = 1; k < RD_LAT; k++) begin
                @(posedge clk); #1;
                chk1("txn_wait_mem_en", mem_en, 1'b1);
                chk1("txn_wait_mem_we", mem_we, 1'b0);
                chk32("txn_wait_mem_addr", mem_addr, a);
                chk1("txn_wait_gnt", c_gnt | x_gnt, 1'b0);
                chk1("txn_wait_rvalid", c_rvalid | x_rvalid, 1'b0);
            end
            @(posedge clk); #1;
            chk1("txn_resp_rvalid_owner", px ? x_rvalid : c_rvalid, 1'b1);
            chk1("txn_resp_rvalid_other", px ? c_rvalid : x_rvalid, 1'b0);
            chk32("txn_resp_rdata", rdata, exp_rd);
            chk1("txn_resp_mem_en", mem_en, 1'b0);
            chk1("txn_resp_busy", busy, 1'b1);
            last_rd = exp_rd;
        end
        @(posedge clk); #1;
        chk1("txn_idle_busy", busy, 1'b0);
        chk1("txn_idle_mem_en", mem_en, 1'b0);
        chk1("txn_idle_pulses", c_gnt | x_gnt | c_rvalid | x_rvalid, 1'b0);
    endtask

    // Random master: holds a request until granted, then maybe issues another at once
    task automatic agent(input bit granted, input int pct, inout logic req, inout logic we,
                         inout logic [31:0] a, inout logic [31:0] d);
        if (granted || !req) begin
            if ((granted && $urandom_range(0, 1) == 1) ||
                (!granted && $urandom_range(0, 99) < 32'(pct))) begin
                req = 1'b1;
                we  = 1'($urandom_range(0, 1));
                a   = 32'($urandom_range(0, 255)) << 2;
                d   = $urandom;
            end else begin
                req = 1'b0;
                we  = 1'($urandom_range(0, 1));
                a   = $urandom;
                d   = $urandom;
            end
        end
    endtask

    typedef struct {
        bit          px;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];
    int   order [$];
    int   exp_order [10];
    int   last_own, cyc, s;
    int   n, free_cyc, dec_cyc, starve;
    bit   cur_x, cur_we, acc, rsp, en_e;
    logic [31:0] cur_addr, cur_wd, cur_rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
        last_rd = '0;

        vecs[0] = '{1'b0, 1'b1, 32'h040, 32'h12345678, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hA5A5F00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hA5A5F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h040, 32'h0,        32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 32'h100, 32'h0BADCAFE, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h0BADCAFE};
        vecs[8] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h5A5A03FC};

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_rdata", rdata, 32'h0);
        chk1("rst_pulses", c_gnt | x_gnt | c_rvalid | x_rvalid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].px, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

        // Both masters request reads continuously; X wins once per STARVE_LIM C grants
        s = 0;
        for (int i = 0; i < 10; i++) begin
            if (s == STARVE_LIM) begin exp_order[i] = 1; s = 0; end
            else begin exp_order[i] = 0; s++; end
        end
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h20;
        last_own = -1; cyc = 0;
        while (order.size() < 10 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (c_gnt) begin order.push_back(0); last_own = 0; end
            if (x_gnt) begin order.push_back(1); last_own = 1; end
            if (c_rvalid) chk32("starve_c_rvalid_owner", 32'(last_own), 32'd0);
            if (x_rvalid) chk32("starve_x_rvalid_owner", 32'(last_own), 32'd1);
        end
        c_req = 1'b0; x_req = 1'b0;
        chk32("starve_grant_count", 32'(order.size()), 32'd10);
        for (int i = 0; i < order.size() && i < 10; i++)
            chk32("starve_order", 32'(order[i]), 32'(exp_order[i]));
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk1("starve_drain", busy, 1'b0);

        // Reset while waiting on read latency
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        @(posedge clk); #1;
        chk1("rstw_gnt", c_gnt, 1'b1);
        c_req = 1'b0;
        @(posedge clk); #1;
        chk1("rstw_wait_en", mem_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstw_mem_en", mem_en, 1'b0);
        chk1("rstw_busy", busy, 1'b0);
        chk32("rstw_mem_addr", mem_addr, 32'h0);
        chk32("rstw_rdata", rdata, 32'h0);
        chk1("rstw_pulses", c_gnt | x_gnt | c_rvalid | x_rvalid, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk1("rstw_no_rvalid", c_rvalid | x_rvalid, 1'b0);
            chk1("rstw_idle", busy, 1'b0);
        end
        run_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678);

        // Randomized two-master run against a transaction-level model
        n = 0; free_cyc = 0; dec_cyc = -10; starve = 0;
        cur_x = 1'b0; cur_we = 1'b1; cur_addr = '0; cur_wd = '0; cur_rd = '0;
        repeat (1500) begin
            @(posedge clk); #1;
            n++;
            acc  = (n == dec_cyc + 1);
            rsp  = !cur_we && (n == dec_cyc + RD_LAT + 1);
            en_e = acc || (!cur_we && n > dec_cyc && n <= dec_cyc + RD_LAT);
            chk1("rnd_c_gnt", c_gnt, acc && !cur_x);
            chk1("rnd_x_gnt", x_gnt, acc && cur_x);
            chk1("rnd_c_rvalid", c_rvalid, rsp && !cur_x);
            chk1("rnd_x_rvalid", x_rvalid, rsp && cur_x);
            chk1("rnd_busy", busy, (n > dec_cyc) && (n < free_cyc));
            chk1("rnd_mem_en", mem_en, en_e);
            chk1("rnd_mem_we", mem_we, acc && cur_we);
            if (en_e) chk32("rnd_mem_addr", mem_addr, cur_addr);
            if (acc && cur_we) chk32("rnd_mem_wdata", mem_wdata, cur_wd);
            if (rsp) last_rd = cur_rd;
            chk32("rnd_rdata", rdata, last_rd);

            agent(acc && !cur_x, 35, c_req, c_we, c_addr, c_wdata);
            agent(acc && cur_x, 25, x_req, x_we, x_addr, x_wdata);

            if (n >= free_cyc && (c_req || x_req)) begin
                if (c_req && !(x_req && starve == STARVE_LIM)) begin
                    cur_x = 1'b0; cur_we = c_we; cur_addr = c_addr; cur_wd = c_wdata;
                    starve = x_req ? ((starve < STARVE_LIM) ? starve + 1 : STARVE_LIM) : 0;
                end else begin
                    cur_x = 1'b1; cur_we = x_we; cur_addr = x_addr; cur_wd = x_wdata;
                    starve = 0;
                end
                dec_cyc = n;
                if (cur_we) begin
                    model_mem[cur_addr] = cur_wd;
                    free_cyc = n + 2;
                end else begin
                    cur_rd = model_mem.exists(cur_addr) ? model_mem[cur_addr]
                                                        : default_word(cur_addr);
                    free_cyc = n + RD_LAT + 2;
                end
            end
        end
        c_req = 1'b0; x_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
